// File: rtl/demux_hm.sv
// demux_hm: routes one byte stream to two one-entry channels
// (A = hour side, B = minute side) by select or ping-pong pointer.
module demux_hm #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sel,
  input  logic         auto_en,
  output logic [W-1:0] a_data,
  output logic         a_valid,
  input  logic         a_ready,
  output logic [W-1:0] b_data,
  output logic         b_valid,
  input  logic         b_ready,
  output logic         ptr,
  output logic [7:0]   a_cnt,
  output logic [7:0]   b_cnt
);

  logic dest;
  logic a_room;
  logic b_room;
  logic acc;
  logic load_a;
  logic load_b;

  // Only the destination channel gates the producer; a stalled
  // non-destination channel never blocks input.
  always_comb begin
    dest     = auto_en ? ptr : sel;
    a_room   = !a_valid || a_ready;
    b_room   = !b_valid || b_ready;
    in_ready = dest ? b_room : a_room;
    acc      = in_valid && in_ready;
    load_a   = acc && !dest;
    load_b   = acc && dest;
  end

  // Channel A buffer: a load wins over a drain in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data  <= '0;
      a_valid <= 1'b0;
      a_cnt   <= 8'd0;
    end else if (load_a) begin
      a_data  <= in_data;
      a_valid <= 1'b1;
      a_cnt   <= a_cnt + 8'd1;
    end else if (a_ready) begin
      a_valid <= 1'b0;
    end
  end

  // Channel B buffer: same behaviour as A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_data  <= '0;
      b_valid <= 1'b0;
      b_cnt   <= 8'd0;
    end else if (load_b) begin
      b_data  <= in_data;
      b_valid <= 1'b1;
      b_cnt   <= b_cnt + 8'd1;
    end else if (b_ready) begin
      b_valid <= 1'b0;
    end
  end

  // Ping-pong pointer: toggles per accept in auto mode, parks at A
  // otherwise so each auto session starts on channel A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (!auto_en) begin
      ptr <= 1'b0;
    end else if (acc) begin
      ptr <= ~ptr;
    end
  end

endmodule
